// File: rtl/counterdown_nch_param.sv
// ---------------------------------------------------------------------------
// counterdown_nch_param
//   Bank of NCH independent WIDTH-bit down counters with parallel load,
//   per-channel enable, wrap / stop-at-zero mode, a registered one-cycle
//   terminal-count pulse and a sticky terminal-count status with clear.
//
// Optional feature macro: COUNTERDOWN_AUTORELOAD_EN
//   When defined, each channel keeps a reload register (reset to RESET_VAL,
//   written by every load). A mode-0 channel at zero then reloads from it
//   instead of wrapping to all-ones.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   en         [NCH]        per-channel count enable
//   load       [NCH]        per-channel parallel load strobe
//   load_val   [NCH*WIDTH]  load values, channel i at [i*WIDTH +: WIDTH]
//   mode       [NCH]        0 = wrap at zero, 1 = stop at zero
//   tc_clr     [NCH]        per-channel clear of the sticky status
//   count      [NCH*WIDTH]  current counts, channel i at [i*WIDTH +: WIDTH]
//   tc         [NCH]        registered one-cycle terminal-count pulse
//   tc_sticky  [NCH]        sticky terminal-count status
//   zero       [NCH]        combinational count_i == 0
// ---------------------------------------------------------------------------
module counterdown_nch_param #(
  parameter int unsigned             WIDTH     = 16,
  parameter int unsigned             NCH       = 4,
  parameter logic [WIDTH-1:0]        RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         en,
  input  logic [NCH-1:0]         load,
  input  logic [NCH*WIDTH-1:0]   load_val,
  input  logic [NCH-1:0]         mode,
  input  logic [NCH-1:0]         tc_clr,
  output logic [NCH*WIDTH-1:0]   count,
  output logic [NCH-1:0]         tc,
  output logic [NCH-1:0]         tc_sticky,
  output logic [NCH-1:0]         zero
);

  // Next count for one channel; load beats enable, enable beats hold.
  function automatic logic [WIDTH-1:0] next_count(
    input logic [WIDTH-1:0] cur,
    input logic             ld,
    input logic [WIDTH-1:0] lv,
    input logic             e,
    input logic             m,
    input logic [WIDTH-1:0] wv
  );
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    if (ld) begin
      nxt = lv;
    end else if (e) begin
      if (cur != '0)  nxt = cur - WIDTH'(1);
      else if (!m)    nxt = wv;
      // mode 1 at zero: hold
    end
    return nxt;
  endfunction

  // Terminal count fires on a 1->0 decrement or on a mode-0 turnover at
  // zero. A load (even of zero) and a stopped mode-1 channel never fire.
  function automatic logic next_tc(
    input logic [WIDTH-1:0] cur,
    input logic             ld,
    input logic             e,
    input logic             m
  );
    return !ld && e && ((cur == WIDTH'(1)) || ((cur == '0) && !m));
  endfunction

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_r;
    logic             tc_r;
    logic             sticky_r;
    logic [WIDTH-1:0] wrap_val;
    logic             tc_set;

`ifdef COUNTERDOWN_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_r;

    always_ff @(posedge clk) begin
      if (reset)        reload_r <= RESET_VAL;
      else if (load[i]) reload_r <= load_val[i*WIDTH +: WIDTH];
    end

    assign wrap_val = reload_r;
`else
    assign wrap_val = '1;
`endif

    assign tc_set = next_tc(cnt_r, load[i], en[i], mode[i]);

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_r    <= RESET_VAL;
        tc_r     <= 1'b0;
        sticky_r <= 1'b0;
      end else begin
        cnt_r <= next_count(cnt_r, load[i], load_val[i*WIDTH +: WIDTH],
                            en[i], mode[i], wrap_val);
        tc_r  <= tc_set;
        // A new terminal count wins over a simultaneous clear.
        if (tc_set)         sticky_r <= 1'b1;
        else if (tc_clr[i]) sticky_r <= 1'b0;
      end
    end

    assign count[i*WIDTH +: WIDTH] = cnt_r;
    assign tc[i]                   = tc_r;
    assign tc_sticky[i]            = sticky_r;
    assign zero[i]                 = (cnt_r == '0);
  end

endmodule

// File: tb/tb_counterdown_nch_param.sv
// ---------------------------------------------------------------------------
// tb_counterdown_nch_param
//   Scoreboard bench for counterdown_nch_param. The driver applies one set of
//   inputs per clock, advances a behavioural model of the bank and queues the
//   expected post-edge outputs; the monitor pops one entry per clock edge and
//   compares it with count, tc, tc_sticky and zero.
// ---------------------------------------------------------------------------
module tb_counterdown_nch_param;
  localparam int W = 16;
  localparam int N = 4;
  localparam logic [W-1:0] ALL1 = {W{1'b1}};

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   en, load, mode, tc_clr;
  logic [N*W-1:0] load_val;
  logic [N*W-1:0] count;
  logic [N-1:0]   tc, tc_sticky, zero;

  counterdown_nch_param #(.WIDTH(W), .NCH(N), .RESET_VAL(ALL1)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .mode(mode), .tc_clr(tc_clr), .count(count), .tc(tc),
    .tc_sticky(tc_sticky), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] cnt;
    logic [N-1:0]   tcv;
    logic [N-1:0]   st;
    logic [N-1:0]   z;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model state
  logic [W-1:0] m_cnt [N];
  logic [W-1:0] m_rl  [N];
  logic         m_tc  [N];
  logic         m_st  [N];

  function automatic logic [N*W-1:0] pack4(input int a, input int b,
                                           input int c, input int d);
    logic [N*W-1:0] v;
    v = '0;
    v[0*W +: W] = W'(a);
    v[1*W +: W] = W'(b);
    v[2*W +: W] = W'(c);
    v[3*W +: W] = W'(d);
    return v;
  endfunction

  // One clock of stimulus plus the matching model step.
  task automatic cyc(input logic r, input logic [N-1:0] e, input logic [N-1:0] l,
                     input logic [N-1:0] m, input logic [N-1:0] c,
                     input logic [N*W-1:0] lv);
    exp_t x;
    @(negedge clk);
    reset = r; en = e; load = l; mode = m; tc_clr = c; load_val = lv;
    for (int i = 0; i < N; i++) begin
      if (r) begin
        m_cnt[i] = ALL1; m_rl[i] = ALL1; m_tc[i] = 1'b0; m_st[i] = 1'b0;
      end else begin
        m_tc[i] = 1'b0;
        if (l[i]) begin
          m_cnt[i] = lv[i*W +: W];
          m_rl[i]  = lv[i*W +: W];
        end else if (e[i]) begin
          if (m_cnt[i] > 0) begin
            m_cnt[i] = m_cnt[i] - 1;
            m_tc[i]  = (m_cnt[i] == 0);
          end else if (!m[i]) begin
`ifdef COUNTERDOWN_AUTORELOAD_EN
            m_cnt[i] = m_rl[i];
`else
            m_cnt[i] = ALL1;
`endif
            m_tc[i] = 1'b1;
          end
        end
        if (m_tc[i])  m_st[i] = 1'b1;
        else if (c[i]) m_st[i] = 1'b0;
      end
      x.cnt[i*W +: W] = m_cnt[i];
      x.tcv[i] = m_tc[i];
      x.st[i]  = m_st[i];
      x.z[i]   = (m_cnt[i] == 0);
    end
    q.push_back(x);
  endtask

  // Monitor: every edge the DUT presents a new output set.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        for (int i = 0; i < N; i++) begin
          checks++;
          if (count[i*W +: W] !== x.cnt[i*W +: W]) begin
            errors++;
            $display("FAIL count[%0d] t=%0t got %h want %h", i, $time,
                     count[i*W +: W], x.cnt[i*W +: W]);
          end
        end
        checks++;
        if (tc !== x.tcv) begin
          errors++;
          $display("FAIL tc t=%0t got %b want %b", $time, tc, x.tcv);
        end
        checks++;
        if (tc_sticky !== x.st) begin
          errors++;
          $display("FAIL tc_sticky t=%0t got %b want %b", $time, tc_sticky, x.st);
        end
        checks++;
        if (zero !== x.z) begin
          errors++;
          $display("FAIL zero t=%0t got %b want %b", $time, zero, x.z);
        end
      end
    end
  end

  initial begin
    int budget;
    logic [N-1:0]   re, rl, rm, rc;
    logic [N*W-1:0] rv;
    reset = 1'b1; en = '0; load = '0; mode = '0; tc_clr = '0; load_val = '0;

    // Reset state
    cyc(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, '0);
    cyc(1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, pack4(1, 2, 3, 4));

    // Channel 0: load 3 then count through 0 into a wrap
    cyc(0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, pack4(3, 0, 0, 0));
    for (int k = 0; k < 5; k++) cyc(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, '0);

    // Channel 1 stop-at-zero: single tc, sticky held
    cyc(0, 4'b0000, 4'b0010, 4'b0010, 4'b0000, pack4(0, 2, 0, 0));
    for (int k = 0; k < 6; k++) cyc(0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, '0);

    // Channel 2: load beats enable; tc set beats clear
    cyc(0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, pack4(0, 0, 16'h0010, 0));
    cyc(0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, pack4(0, 0, 1, 0));
    cyc(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, '0);
    cyc(0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, '0);
    // Load of zero must not fire tc
    cyc(0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, pack4(0, 0, 0, 0));

    // All channels, independent counts; then freeze channel 1
    cyc(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, pack4(5, 9, 0, 16'hFFFF));
    for (int k = 0; k < 4; k++) cyc(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, '0);
    for (int k = 0; k < 3; k++) cyc(0, 4'b1101, 4'b0000, 4'b0000, 4'b0000, '0);

    // Reset mid-count with every sticky set
    cyc(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, pack4(1, 1, 1, 1));
    cyc(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, '0);
    cyc(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, '0);
    cyc(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, '0);

    // Mode 0 with load 2: reload or wrap depending on build
    cyc(0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, pack4(2, 0, 0, 0));
    for (int k = 0; k < 6; k++) cyc(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, '0);

    // Randomised traffic with small load values so zero is visited often
    for (int k = 0; k < 400; k++) begin
      re = N'($urandom);
      rl = N'($urandom) & N'($urandom) & N'($urandom);
      rm = N'($urandom);
      rc = N'($urandom) & N'($urandom);
      rv = '0;
      for (int i = 0; i < N; i++)
        rv[i*W +: W] = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 4));
      cyc(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, re, rl, rm, rc, rv);
    end
    cyc(0, '0, '0, '0, '0, '0);

    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/counterdown_nch_param.md
Name: counterdown_nch_param

Overview:
- Parametrised multi-channel down-counter bank: NCH independent WIDTH-bit down counters.
- Adds parallel load, per-channel enable, stop-at-zero or wrap mode, a terminal-count pulse and a sticky terminal-count status with clear.
- Single clock domain with a synchronous reset. Used as a general timer/counter resource in the simple_registers family.

Parameters:
- WIDTH, 16, bit width of each counter (min 2)
- NCH, 4, number of channels (min 1)
- RESET_VAL, {WIDTH{1'b1}}, value loaded into every counter on reset

Ports:
- clk  input  1  rising-edge clock for all channels
- reset  input  1  synchronous, active-high reset
- en  input  NCH  per-channel count enable; bit i controls channel i
- load  input  NCH  per-channel parallel load strobe
- load_val  input  NCH*WIDTH  load values; channel i uses bits [i*WIDTH +: WIDTH]
- mode  input  NCH  per channel: 0 = wrap at zero, 1 = stop at zero
- tc_clr  input  NCH  per-channel clear of the sticky status
- count  output  NCH*WIDTH  current counts; channel i uses bits [i*WIDTH +: WIDTH]
- tc  output  NCH  registered one-cycle terminal-count pulse
- tc_sticky  output  NCH  sticky terminal-count status
- zero  output  NCH  combinational flag, count_i == 0

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. All state updates on the rising edge of clk.
- Reset, sampled on a clk edge: every count_i = RESET_VAL, tc = 0, tc_sticky = 0. Reset overrides all other inputs.
- Per-channel update priority, highest first: reset, load, en, hold.
  - load_i = 1: count_i <= load_val_i. tc_i = 0 that cycle. Load has priority over en.
  - en_i = 1, count_i != 0: count_i <= count_i - 1. Latency 1 cycle.
  - en_i = 1, count_i == 0, mode_i = 0: count_i <= all-ones (wrap).
  - en_i = 1, count_i == 0, mode_i = 1: count_i holds at 0.
  - en_i = 0 and load_i = 0: count_i holds.
- tc_i (registered):
  - Goes to 1 on the edge where a decrement moves count_i from 1 to 0.
  - Also goes to 1 on a wrap from 0 to all-ones (mode 0).
  - Otherwise 0.
  - Is never asserted repeatedly while a mode-1 channel sits at 0.
  - A load that writes 0 does not assert tc_i.
- tc_sticky_i:
  - Set on any edge where tc_i is being set.
  - Cleared by tc_clr_i.
  - Set wins over a simultaneous clear.
  - Otherwise holds.
- zero_i: purely combinational from count_i; no added latency.
- Channels are fully independent. Activity on channel j never affects channel i.
- Arithmetic is unsigned modulo 2^WIDTH. No carry or borrow between channels.
- Reset mid-count: the next edge forces RESET_VAL; pending tc and sticky bits are lost.

Optional Feature:
- Macro: COUNTERDOWN_AUTORELOAD_EN.
- Defined:
  - Each channel has a WIDTH-bit reload register. It is reset to RESET_VAL and captures load_val_i whenever load_i = 1.
  - In mode 0, en_i = 1 at count 0 gives count_i <= reload_i instead of all-ones.
  - tc_i still asserts on that transition.
  - Mode 1 behaviour is unchanged.
- Not defined: no reload registers exist; mode 0 wraps to all-ones as specified above.

Test Plan:
- Reset, then load_val_0 = 3, load pulse, en_0 = 1 held: count_0 = 3, 2, 1, 0, 0xFFFF on successive edges. tc_0 = 1 only in the cycle count_0 becomes 0 and in the cycle of the 0 to 0xFFFF wrap. zero_0 = 1 for one cycle.
- Channel 1, mode_1 = 1, load 2, en held for 6 cycles: count_1 = 2, 1, 0, 0, 0, 0. tc_1 pulses exactly once. tc_sticky_1 is set and stays 1.
- Simultaneous load_2 = 1 (value 0x0010) and en_2 = 1: count_2 = 0x0010 next edge, not 0x000F. Same cycle, tc_clr_2 = 1 with tc_2 being set: tc_sticky_2 = 1.
- All four channels enabled with different loads (5, 9, 0, 0xFFFF): each decrements independently. Gating en_1 low freezes only channel 1.
- Assert reset mid-count with tc_sticky = 4'b1111: next edge gives all counts 0xFFFF, tc = 0, tc_sticky = 0.
- With COUNTERDOWN_AUTORELOAD_EN, mode 0, load 2, en held: count = 2, 1, 0, 2, 1, 0. tc pulses each time count reaches 0 and on each 0 to 2 reload. Rebuild without the macro: count wraps to 0xFFFF.
